// File: rtl/mem_server.sv
// Word-organised single-port memory serving a fetch channel and a data channel,
// with alternating arbitration, programmable wait states and one-cycle acks.
module mem_server #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        busy
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic CH_F  = 1'b0;
  localparam logic CH_D  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [31:0]       mem [0:DEPTH-1];
  logic              ch_reg, last_grant_reg, we_reg, mis_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [31:0]       wdata_reg, if_rdata_reg, d_rdata_reg;
  logic [3:0]        cnt_reg;
  logic              if_ack_reg, d_ack_reg, d_err_reg;
  logic              grant_any, grant_d, access, mem_we;

  // Contention goes to whichever channel was not served last.
  assign grant_any = if_req | d_req;
  assign grant_d   = d_req & (~if_req | (last_grant_reg == CH_F));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_any) state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == 4'd0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != S_IDLE);
    access = (state_reg == S_WAIT) && (cnt_reg == 4'd0);
    mem_we = access && (ch_reg == CH_D) && we_reg && !mis_reg;
  end

  // Array has no reset: contents survive reset, and an aborted access never
  // reaches its write edge because the state register is cleared first.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_reg] <= wdata_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_reg         <= CH_F;
      last_grant_reg <= CH_F;
      we_reg         <= 1'b0;
      mis_reg        <= 1'b0;
      idx_reg        <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      if_ack_reg     <= 1'b0;
      d_ack_reg      <= 1'b0;
      d_err_reg      <= 1'b0;
    end else begin
      if_ack_reg <= 1'b0;
      d_ack_reg  <= 1'b0;
      d_err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (grant_any) begin
            ch_reg         <= grant_d;
            last_grant_reg <= grant_d;
            idx_reg        <= grant_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
            we_reg         <= grant_d & d_we;
            mis_reg        <= grant_d & (d_addr[1:0] != 2'b00);
            wdata_reg      <= d_wdata;
            cnt_reg        <= 4'(WAIT);
          end
        end
        S_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (ch_reg == CH_D) begin
            d_ack_reg <= 1'b1;
            d_err_reg <= mis_reg;
            if (mis_reg)      d_rdata_reg <= '0;
            else if (!we_reg) d_rdata_reg <= mem[idx_reg];
          end else begin
            if_ack_reg   <= 1'b1;
            if_rdata_reg <= mem[idx_reg];
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = if_rdata_reg;
  assign if_ack   = if_ack_reg;
  assign d_rdata  = d_rdata_reg;
  assign d_ack    = d_ack_reg;
  assign d_err    = d_err_reg;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

endmodule
